// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
package mem_pkg;

    // funct3 load/store size encoding as produced by the decoder
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_type_e;

    // Responder transaction states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Pick the addressed lane out of a word and sign/zero extend it.
    // Unknown codes return zero; the error path masks them anyway.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  offset,
                                                input logic [2:0]  mtype);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {offset, 3'b000};
        case (mtype)
            MEM_B:   res = {{24{sh[7]}}, sh[7:0]};
            MEM_H:   res = {{16{sh[15]}}, sh[15:0]};
            MEM_W:   res = word;
            MEM_BU:  res = {24'd0, sh[7:0]};
            MEM_HU:  res = {16'd0, sh[15:0]};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Byte-enable mask for a store of the given size at the given offset.
    function automatic logic [3:0] store_strobe(input logic [1:0] offset,
                                                input logic [2:0] mtype);
        logic [3:0] strb;
        case (mtype)
            MEM_B:   strb = 4'b0001 << offset;
            MEM_H:   strb = offset[1] ? 4'b1100 : 4'b0011;
            MEM_W:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Combinational lane steering and access checking for the latched request.
module dmem_lane_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic [31:0] addr_i,
    input  logic        wr_i,
    input  logic [2:0]  type_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  strb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic misalign_s;
    logic range_s;
    logic illegal_s;

    // Classify the access: alignment, array bounds and legal size code
    always_comb begin
        misalign_s = 1'b0;
        case (type_i)
            MEM_H, MEM_HU: misalign_s = addr_i[0];
            MEM_W:         misalign_s = (addr_i[1:0] != 2'b00);
            default:       misalign_s = 1'b0;
        endcase

        range_s = ({2'b00, addr_i[31:2]} >= 32'(DEPTH));

        // Stores only know signed-size codes; loads reject the unused codes
        if (wr_i) begin
            illegal_s = !((type_i == MEM_B) || (type_i == MEM_H) || (type_i == MEM_W));
        end else begin
            illegal_s = (type_i == 3'b011) || (type_i == 3'b110) || (type_i == 3'b111);
        end

        err_o = misalign_s | range_s | illegal_s;
    end

    // Replicate store data across lanes so the strobe alone selects the target
    always_comb begin
        wdata_o = 32'd0;
        case (type_i)
            MEM_B:   wdata_o = {4{wdata_i[7:0]}};
            MEM_H:   wdata_o = {2{wdata_i[15:0]}};
            MEM_W:   wdata_o = wdata_i;
            default: wdata_o = 32'd0;
        endcase
    end

    // Strobes are suppressed on any error so a bad store leaves the array untouched
    always_comb begin
        strb_o  = 4'b0000;
        rdata_o = load_extend(rword_i, addr_i[1:0], type_i);
        if (err_o) begin
            strb_o = 4'b0000;
        end else begin
            strb_o = store_strobe(addr_i[1:0], type_i);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory target: one request in flight, programmable
// wait states, byte/half/word access and an error-flagged response.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    // Counter starts at WAIT_CYCLES so the commit edge lands WAIT_CYCLES+1
    // edges after acceptance, with rsp_valid visible the cycle after that.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;
    logic [31:0]        addr_q;
    logic               wr_q;
    logic [2:0]         type_q;
    logic [31:0]        wdata_q;
    logic [31:0]        mem_q [DEPTH];

    logic [IDX_W-1:0]   idx_s;
    logic [31:0]        rword_s;
    logic [3:0]         strb_s;
    logic [31:0]        wdata_al_s;
    logic [31:0]        ld_data_s;
    logic               err_s;
    logic               commit_s;

    assign idx_s    = addr_q[IDX_W+1:2];
    assign rword_s  = mem_q[idx_s];
    assign commit_s = (state_q == WAIT) && (cnt_q == 4'd0);

    dmem_lane_ctrl #(
        .DEPTH (DEPTH)
    ) u_lane (
        .addr_i  (addr_q),
        .wr_i    (wr_q),
        .type_i  (type_q),
        .wdata_i (wdata_q),
        .rword_i (rword_s),
        .strb_o  (strb_s),
        .wdata_o (wdata_al_s),
        .rdata_o (ld_data_s),
        .err_o   (err_s)
    );

    // Request/response FSM with wait-state counter and registered handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            addr_q      <= 32'd0;
            wr_q        <= 1'b0;
            type_q      <= 3'd0;
            wdata_q     <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr;
                        wr_q        <= req_wr;
                        type_q      <= req_type;
                        wdata_q     <= req_wdata;
                        cnt_q       <= WAIT_LOAD;
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_s;
                        rsp_rdata_q <= (err_s || wr_q) ? 32'd0 : ld_data_s;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= 4'd0;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    // Data array: cleared by reset, byte-masked write only at a clean store commit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (commit_s && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_s[b]) begin
                    mem_q[idx_s][8*b +: 8] <= wdata_al_s[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES 2 and 0), a vector
// table driven through a response scoreboard, plus backpressure and reset sequences.
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        int          u;
        logic        wr;
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    logic        clk;
    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        req_wr    [2];
    logic [2:0]  req_type  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_w2 (
        .clock     (clk),
        .reset     (reset[0]),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_addr  (req_addr[0]),
        .req_wr    (req_wr[0]),
        .req_type  (req_type[0]),
        .req_wdata (req_wdata[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut_w0 (
        .clock     (clk),
        .reset     (reset[1]),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_addr  (req_addr[1]),
        .req_wr    (req_wr[1]),
        .req_type  (req_type[1]),
        .req_wdata (req_wdata[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wc_of(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request, wait for acceptance, push its expected response.
    // Returns at the falling edge after the accepting edge.
    task automatic issue(input int u, input logic wr, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d,
                         input exp_t e, input bit keep);
        int n;
        n = 0;
        @(negedge clk);
        req_valid[u] = 1'b1;
        req_wr[u]    = wr;
        req_type[u]  = t;
        req_addr[u]  = a;
        req_wdata[u] = d;
        while (req_ready[u] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 32'(n < 100), 32'd1);
        @(posedge clk);
        sb_q.push_back(e);
        @(negedge clk);
        if (!keep) begin
            req_valid[u] = 1'b0;
            req_wr[u]    = ~wr;
            req_type[u]  = 3'b111;
            req_addr[u]  = ~a;
            req_wdata[u] = ~d;
        end
    endtask

    // Wait for the response, check latency and contents, complete the handshake.
    task automatic collect(input int u, input string name);
        int   lat;
        exp_t e;
        lat = 1;
        while (rsp_valid[u] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'(wc_of(u) + 2));
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_rdata"}, rsp_rdata[u], e.rdata);
            chk({name, "_err"}, 32'(rsp_err[u]), 32'(e.err));
        end
        rsp_ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_valid_drop"}, 32'(rsp_valid[u]), 32'd0);
    endtask

    task automatic add(input int u, input logic wr, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] er, input logic ee);
        vec_t v;
        v.u = u; v.wr = wr; v.t = t; v.a = a; v.d = d; v.er = er; v.ee = ee;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t e;
        int   lat;

        for (int u = 0; u < 2; u++) begin
            reset[u]     = 1'b1;
            req_valid[u] = 1'b0;
            req_addr[u]  = 32'd0;
            req_wr[u]    = 1'b0;
            req_type[u]  = 3'd0;
            req_wdata[u] = 32'd0;
            rsp_ready[u] = 1'b1;
        end

        // WAIT_CYCLES = 2 instance
        add(0, 1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
        add(0, 1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        add(0, 1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0);
        add(0, 1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b0);
        add(0, 1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0);
        add(0, 1'b0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 1'b0);
        add(0, 1'b1, 3'b000, 32'h11,  32'h11223355, 32'h0,        1'b0);
        add(0, 1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 1'b0);
        add(0, 1'b1, 3'b001, 32'h12,  32'hABCD1234, 32'h0,        1'b0);
        add(0, 1'b0, 3'b010, 32'h10,  32'h0,        32'h123455EF, 1'b0);
        add(0, 1'b0, 3'b010, 32'h12,  32'h0,        32'h0,        1'b1);
        add(0, 1'b1, 3'b001, 32'h13,  32'hFFFF,     32'h0,        1'b1);
        add(0, 1'b0, 3'b010, 32'h400, 32'h0,        32'h0,        1'b1);
        add(0, 1'b1, 3'b010, 32'h11,  32'hFFFFFFFF, 32'h0,        1'b1);
        add(0, 1'b1, 3'b100, 32'h10,  32'hFF,       32'h0,        1'b1);
        add(0, 1'b1, 3'b101, 32'h10,  32'hFFFF,     32'h0,        1'b1);
        add(0, 1'b1, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1);
        add(0, 1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1);
        add(0, 1'b0, 3'b110, 32'h10,  32'h0,        32'h0,        1'b1);
        add(0, 1'b0, 3'b111, 32'h10,  32'h0,        32'h0,        1'b1);
        add(0, 1'b0, 3'b010, 32'h10,  32'h0,        32'h123455EF, 1'b0);
        add(0, 1'b0, 3'b000, 32'h11,  32'h0,        32'h00000055, 1'b0);
        add(0, 1'b0, 3'b001, 32'h10,  32'h0,        32'h000055EF, 1'b0);
        add(0, 1'b0, 3'b101, 32'h12,  32'h0,        32'h00001234, 1'b0);
        add(0, 1'b0, 3'b000, 32'h10,  32'h0,        32'hFFFFFFEF, 1'b0);
        add(0, 1'b0, 3'b100, 32'h12,  32'h0,        32'h00000034, 1'b0);
        add(0, 1'b1, 3'b010, 32'h3FC, 32'h80000001, 32'h0,        1'b0);
        add(0, 1'b1, 3'b001, 32'h3FC, 32'h00007777, 32'h0,        1'b0);
        add(0, 1'b0, 3'b010, 32'h3FC, 32'h0,        32'h80007777, 1'b0);
        add(0, 1'b0, 3'b000, 32'h3FF, 32'h0,        32'hFFFFFF80, 1'b0);
        add(0, 1'b0, 3'b101, 32'h3FE, 32'h0,        32'h00008000, 1'b0);
        add(0, 1'b1, 3'b010, 32'h400, 32'h00001234, 32'h0,        1'b1);
        add(0, 1'b0, 3'b010, 32'h0,   32'h0,        32'h0,        1'b0);
        add(0, 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,   32'h0,        1'b1);
        // WAIT_CYCLES = 0 instance
        add(1, 1'b1, 3'b010, 32'h10,  32'hCAFEF00D, 32'h0,        1'b0);
        add(1, 1'b0, 3'b010, 32'h10,  32'h0,        32'hCAFEF00D, 1'b0);
        add(1, 1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFCAFE, 1'b0);
        add(1, 1'b0, 3'b101, 32'h12,  32'h0,        32'h0000CAFE, 1'b0);
        add(1, 1'b1, 3'b000, 32'h12,  32'h00000007, 32'h0,        1'b0);
        add(1, 1'b0, 3'b010, 32'h10,  32'h0,        32'hCA07F00D, 1'b0);
        add(1, 1'b0, 3'b010, 32'h11,  32'h0,        32'h0,        1'b1);

        // Reset values while reset is held
        #3;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst_req_ready%0d", u), 32'(req_ready[u]), 32'd1);
            chk($sformatf("rst_rsp_valid%0d", u), 32'(rsp_valid[u]), 32'd0);
            chk($sformatf("rst_rsp_rdata%0d", u), rsp_rdata[u], 32'd0);
            chk($sformatf("rst_rsp_err%0d", u), 32'(rsp_err[u]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            e.rdata = vecs[i].er;
            e.err   = vecs[i].ee;
            issue(vecs[i].u, vecs[i].wr, vecs[i].t, vecs[i].a, vecs[i].d, e, 1'b0);
            collect(vecs[i].u, $sformatf("v%0d", i));
        end

        // Backpressure: hold the response, a second request waits for the handshake
        rsp_ready[0] = 1'b0;
        e.rdata = 32'h123455EF;
        e.err   = 1'b0;
        issue(0, 1'b0, 3'b010, 32'h10, 32'h0, e, 1'b1);
        req_addr[0] = 32'h14;
        lat = 1;
        while (rsp_valid[0] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_lat", 32'(lat), 32'd4);
        e = sb_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid%0d", k), 32'(rsp_valid[0]), 32'd1);
            chk($sformatf("bp_rdata%0d", k), rsp_rdata[0], e.rdata);
            chk($sformatf("bp_err%0d", k), 32'(rsp_err[0]), 32'(e.err));
            chk($sformatf("bp_req_ready%0d", k), 32'(req_ready[0]), 32'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_hs_valid_drop", 32'(rsp_valid[0]), 32'd0);
        chk("bp_hs_req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        e.rdata = 32'h0;
        e.err   = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid[0] = 1'b0;
        collect(0, "bp_second");

        // Reset during the wait states drops the store (WAIT_CYCLES = 2 then 0)
        for (int u = 0; u < 2; u++) begin
            e.rdata = 32'h0;
            e.err   = 1'b0;
            issue(u, 1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, e, 1'b0);
            reset[u] = 1'b1;
            #1;
            chk($sformatf("arst_req_ready%0d", u), 32'(req_ready[u]), 32'd1);
            chk($sformatf("arst_rsp_valid%0d", u), 32'(rsp_valid[u]), 32'd0);
            chk($sformatf("arst_rsp_rdata%0d", u), rsp_rdata[u], 32'd0);
            chk($sformatf("arst_rsp_err%0d", u), 32'(rsp_err[u]), 32'd0);
            void'(sb_q.pop_back());
            @(negedge clk);
            reset[u] = 1'b0;
            issue(u, 1'b0, 3'b010, 32'h20, 32'h0, e, 1'b0);
            collect(u, $sformatf("arst_lw20_%0d", u));
            issue(u, 1'b0, 3'b010, 32'h10, 32'h0, e, 1'b0);
            collect(u, $sformatf("arst_lw10_%0d", u));
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
